wb_result_stage: RTL



---
 rtl/otter_pkg.sv | 27 ++
 rtl/load_extend.sv | 33 +++
 rtl/wb_result_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER datapath types: writeback source select, load funct3 codes and
// the writeback entry carried from execute/memory to the register file.
package otter_pkg;

    localparam int unsigned OTTER_XLEN = 32;
    localparam int unsigned REG_AW     = 5;

    typedef enum logic [1:0] {
        WB_PC4 = 2'b00,
        WB_CSR = 2'b01,
        WB_MEM = 2'b10,
        WB_ALU = 2'b11
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                  we;
        logic [REG_AW-1:0]     rd;
        logic [OTTER_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half of an aligned memory word and sign- or
// zero-extends it according to the load funct3.
module load_extend
    import otter_pkg::*;
#(
    parameter int unsigned XLEN = OTTER_XLEN
) (
    input  logic [XLEN-1:0] mem_dout,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] value
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Halves only look at byte_off[1]; a misaligned low bit is ignored.
    assign lane_byte = mem_dout[{byte_off, 3'b000} +: 8];
    assign lane_half = mem_dout[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        value = mem_dout;
        case (funct3)
            F3_LB:   value = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            F3_LBU:  value = {{(XLEN-8){1'b0}}, lane_byte};
            F3_LH:   value = {{(XLEN-16){lane_half[15]}}, lane_half};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, lane_half};
            F3_LW:   value = mem_dout;
            default: value = mem_dout;
        endcase
    end

endmodule

// File: rtl/wb_result_stage.sv
// Writeback stage: selects the result, buffers it in a small FIFO, drives the
// register-file write port from the head and forwards pending writes.
module wb_result_stage
    import otter_pkg::*;
#(
    parameter int unsigned XLEN  = OTTER_XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      rf_wr_sel,
    input  logic            reg_write,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] csr_rd,
    input  logic [XLEN-1:0] mem_dout,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      byte_off,
    input  logic            wb_stall,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_entry_t          buf_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [XLEN-1:0]    load_val;
    logic [XLEN-1:0]    wb_val;
    wb_entry_t          new_entry;
    wb_entry_t          head;
    logic               push, pop, not_empty;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .mem_dout (mem_dout),
        .funct3   (mem_funct3),
        .byte_off (byte_off),
        .value    (load_val)
    );

    always_comb begin
        wb_val = alu_result;
        case (wb_sel_t'(rf_wr_sel))
            WB_PC4:  wb_val = pc_plus4;
            WB_CSR:  wb_val = csr_rd;
            WB_MEM:  wb_val = load_val;
            WB_ALU:  wb_val = alu_result;
            default: wb_val = alu_result;
        endcase
    end

    // Writes to x0 are turned into non-writing entries at accept time.
    assign new_entry.we   = reg_write && (rd != 5'd0);
    assign new_entry.rd   = rd;
    assign new_entry.data = wb_val;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q < DEPTH_C);
    assign push      = in_valid && in_ready;
    assign pop       = not_empty && !wb_stall;
    assign head      = buf_q[rd_ptr_q];

    assign rf_we = pop && head.we;
    assign rf_wa = not_empty ? head.rd   : 5'd0;
    assign rf_wd = not_empty ? head.data : '0;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: validity comes from count/rd_ptr only.
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_q[wr_ptr_q] <= new_entry;
        end
    end

    // Walk oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && buf_q[idx].we) begin
                if (buf_q[idx].rd == q_rs1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = buf_q[idx].data;
                end
                if (buf_q[idx].rd == q_rs2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = buf_q[idx].data;
                end
            end
        end
    end

endmodule
